// File: rtl/sat_up_intlv_ctrl.sv
// -----------------------------------------------------------------------------
// sat_up_intlv_ctrl
//
// Per-frame controller for the SAT-UPLINK block interleaver. A frame starts
// with a link ID, which is registered and driven to an external length lookup.
// After the lookup latency the frame length is captured. The interleaver RAM
// is then written linearly (m_len symbols) and read back column-major over a
// COLS-wide matrix. Matrix cells beyond the frame length are skipped with
// one bubble cycle each.
//
// Ports
//   clk_i          clock
//   rst_i          asynchronous, active-high reset
//   start_i        frame start pulse (honoured in IDLE only)
//   link_id_i      link ID, sampled with start_i
//   lut_link_id_o  registered link ID driven to the length lookup
//   lut_m_len_i    frame length returned by the lookup (0 = unsupported ID)
//   wr_valid_i     input symbol valid
//   wr_en_o        RAM write strobe
//   wr_addr_o      RAM write address
//   rd_ready_i     downstream can accept a symbol
//   rd_en_o        RAM read strobe
//   rd_addr_o      RAM read address
//   rd_last_o      qualifies the final read of the frame
//   busy_o         high whenever the controller is not idle
//   done_o         one-cycle pulse at frame completion
//   err_o          one-cycle pulse when the lookup returns length 0
//
// States
//   S_IDLE   | waiting for start_i
//   S_LOOKUP | waiting LUT_LAT clocks for the length lookup, then capture
//   S_WRITE  | linear RAM write of len_q symbols
//   S_READ   | column-major pruned RAM read of len_q symbols
//   S_DONE   | one terminating cycle: done_o, or err_o if len_q is 0
// -----------------------------------------------------------------------------
module sat_up_intlv_ctrl #(
    parameter int COLS    = 32,
    parameter int LEN_W   = 13,
    parameter int LUT_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [5:0]       link_id_i,
    output logic [5:0]       lut_link_id_o,
    input  logic [LEN_W-1:0] lut_m_len_i,
    input  logic             wr_valid_i,
    output logic             wr_en_o,
    output logic [LEN_W-1:0] wr_addr_o,
    input  logic             rd_ready_i,
    output logic             rd_en_o,
    output logic [LEN_W-1:0] rd_addr_o,
    output logic             rd_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int C_W  = $clog2(COLS);
    localparam int R_W  = LEN_W - C_W;
    localparam int LK_W = (LUT_LAT < 1) ? 1 : $clog2(LUT_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [LK_W-1:0]  lk_cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [R_W-1:0]   last_row_q;
    logic [LEN_W-1:0] wcnt_q;
    logic [LEN_W-1:0] rcnt_q;
    logic [R_W-1:0]   r_q;
    logic [C_W-1:0]   c_q;
    logic [5:0]       lut_link_id_q;

    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] cand;
    logic             pruned;
    logic             lk_hit;
    logic             wr_fire;
    logic             wr_fin;
    logic             rd_fire;
    logic             rd_fin;
    logic [R_W:0]     rows_d;
    logic [R_W-1:0]   last_row_d;

    assign len_m1 = len_q - LEN_W'(1);
    assign lk_hit = (lk_cnt_q == LK_W'(LUT_LAT));

    // Row-major RAM address of the current matrix cell: r*COLS + c.
    assign cand   = {r_q, c_q};
    assign pruned = (cand >= len_q);

    assign wr_fire = (state_q == S_WRITE) && wr_valid_i;
    assign wr_fin  = wr_fire && (wcnt_q == len_m1);
    assign rd_fire = (state_q == S_READ) && !pruned && rd_ready_i;
    assign rd_fin  = rd_fire && (rcnt_q == len_m1);

    // rows = ceil(len/COLS) from a shift plus a remainder test. Only rows-1
    // is kept: it is the wrap point of the row counter and always fits R_W
    // bits, whereas rows itself can need one more bit.
    assign rows_d     = (R_W+1)'(lut_m_len_i >> C_W)
                      + (R_W+1)'(|lut_m_len_i[C_W-1:0]);
    assign last_row_d = R_W'(rows_d - (R_W+1)'(1));

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (lk_hit) begin
                    // A zero length still passes through S_DONE so that
                    // err_o is seen while busy_o is high.
                    state_d = (lut_m_len_i == '0) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (wr_fin) state_d = S_READ;
            end
            S_READ: begin
                if (rd_fin) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy_o    = 1'b0;
        wr_en_o   = 1'b0;
        rd_en_o   = 1'b0;
        rd_last_o = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        case (state_q)
            S_LOOKUP: begin
                busy_o = 1'b1;
            end
            S_WRITE: begin
                busy_o  = 1'b1;
                wr_en_o = wr_fire;
            end
            S_READ: begin
                busy_o    = 1'b1;
                rd_en_o   = rd_fire;
                rd_last_o = rd_fin;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = (len_q != '0);
                err_o  = (len_q == '0);
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign lut_link_id_o = lut_link_id_q;
    assign wr_addr_o     = wcnt_q;
    assign rd_addr_o     = cand;

    // Datapath: lookup counter, length capture, write/read pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lk_cnt_q      <= '0;
            len_q         <= '0;
            last_row_q    <= '0;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            r_q           <= '0;
            c_q           <= '0;
            lut_link_id_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        lut_link_id_q <= link_id_i;
                        lk_cnt_q      <= '0;
                        len_q         <= '0;
                        last_row_q    <= '0;
                        wcnt_q        <= '0;
                        rcnt_q        <= '0;
                        r_q           <= '0;
                        c_q           <= '0;
                    end
                end
                S_LOOKUP: begin
                    if (lk_hit) begin
                        len_q      <= lut_m_len_i;
                        last_row_q <= last_row_d;
                    end else begin
                        lk_cnt_q <= lk_cnt_q + LK_W'(1);
                    end
                end
                S_WRITE: begin
                    if (wr_fire) wcnt_q <= wcnt_q + LEN_W'(1);
                end
                S_READ: begin
                    if (rd_fire) rcnt_q <= rcnt_q + LEN_W'(1);
                    // A pruned cell costs one bubble and is skipped without
                    // waiting for rd_ready_i; a real cell waits for its read.
                    if (rd_fire || pruned) begin
                        if (r_q == last_row_q) begin
                            r_q <= '0;
                            c_q <= c_q + C_W'(1);
                        end else begin
                            r_q <= r_q + R_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
